spi_host_ctrl: RTL and testbench
================================

Name: spi_host_ctrl

Overview:
SPI controller (host) that runs register transactions against the team's SPI register-bank slave: single-register writes and reads over cs_n/sclk/mosi/miso. Used on test chips and FPGA boards to configure the RSA register bank (P/E/M/Const, action bits) and read back status and ciphertext, with no external microcontroller. Each transaction is a valid/ready request, and a one-cycle response pulse reports completion.

Parameters:
WIDTH, 8, register data width; data-phase bit count.
ADDR_WIDTH, 3, register address width; must be <= 7.
CLK_DIV, 4, sclk half-period in clk cycles; legal range 2..255.

Ports:
clk  input  1  system clock
rstb  input  1  reset, asynchronous, active-low
ena  input  1  global enable; low freezes all state
req_valid  input  1  transaction request
req_ready  output  1  high only in IDLE; request accepted when valid&ready
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  register address
req_wdata  input  WIDTH  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  WIDTH  read data; valid with rsp_valid on reads
busy  output  1  high from accept until return to IDLE
spi_cs_n  output  1  chip select, active-low
spi_clk  output  1  SPI clock, mode 0 (idle low)
spi_mosi  output  1  host-to-slave data, MSB first
spi_miso  input  1  slave-to-host data

Behaviour:
- Reset values: spi_cs_n=1, spi_clk=0, spi_mosi=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0. All SPI outputs are registered.
- Frame: 8-bit command, then WIDTH data bits, MSB first, for N=8+WIDTH bits total.
- Command byte: bit7=req_write; bits6:ADDR_WIDTH=0; bits[ADDR_WIDTH-1:0]=req_addr.
- Data phase on writes: mosi carries req_wdata.
- Data phase on reads: mosi=0, and the WIDTH miso bits form rsp_rdata.
- Accept: on the edge where req_valid&req_ready&ena, the block latches write/addr/wdata into a shift register, leaves IDLE, and sets busy=1 and req_ready=0. req_valid is ignored when not in IDLE.
- SETUP: spi_cs_n=0, spi_clk=0, mosi=command bit7. Lasts CLK_DIV cycles.
- SHIFT (N bits): each bit has spi_clk=1 for CLK_DIV cycles, then spi_clk=0 for CLK_DIV cycles.
- miso sampling: miso is sampled on the clk edge that ends the high phase (the 1->0 transition). This tolerates up to CLK_DIV-1 cycles of slave synchroniser latency.
- mosi update: the next mosi bit is driven on that same 1->0 edge. After the last bit, mosi returns to 0.
- cs_n low duration: exactly CLK_DIV*(1+2N) cycles. For the default, 4*33=132.
- DONE: on the first cycle with spi_cs_n=1, rsp_valid=1 for exactly one cycle.
  - Reads: rsp_rdata updates on that same edge.
  - Writes: rsp_rdata holds its previous value.
- GAP: spi_cs_n stays 1 for CLK_DIV cycles. The block then enters IDLE with req_ready=1 and busy=0.
- Back-to-back: minimum spacing between cs_n deassertion and the next cs_n assertion is CLK_DIV+1 cycles.
- FSM states: IDLE -> SETUP -> SHIFT -> DONE -> GAP -> IDLE. Bit counter counts 0..N-1; divider counter counts 0..CLK_DIV-1. There are no other transitions.
- ena=0: the FSM, counters and shift registers hold, and the SPI outputs hold their levels (sclk stretches). rsp_valid is forced to 0 while ena=0; a pending pulse is emitted once ena returns. Requests are not accepted while ena=0.
- Reset mid-frame: rstb low returns all outputs to their reset values immediately (asynchronous). cs_n rises and the slave discards the partial frame. No rsp_valid is generated for the aborted transaction.
- Address 0 is written normally (spare register in the slave); reading address 0 returns the slave status.

Test Plan:
- Write addr 2 = 0xA5, CLK_DIV=4 -> mosi samples at sclk rises are 0x82 then 0xA5. cs_n low for 132 cycles. rsp_valid pulses once on the cs_n rise. rsp_rdata unchanged.
- Read addr 6 against a slave model returning 0x3C with 2-cycle miso latency -> command byte 0x06, mosi=0 in data phase, rsp_rdata=0x3C coincident with rsp_valid.
- Two requests held valid back-to-back (write 3=0x11, read 3) -> second accepted only when req_ready rises. cs_n high for 5 cycles between frames. Read returns 0x11.
- ena dropped for 20 cycles mid-SHIFT -> sclk/mosi/cs_n frozen. Frame completes correctly, with cs_n low for 152 cycles total.
- rstb asserted at bit 5 of a write -> cs_n=1, sclk=0, mosi=0 immediately. No rsp_valid. Next request after reset completes normally.
- req_valid toggled while busy -> no effect on the ongoing frame. CLK_DIV=2 build: cs_n low for 66 cycles.

Source files
------------

// File: rtl/spi_host_ctrl.sv
// spi_host_ctrl: SPI mode-0 host issuing single-register write/read frames
// (8-bit command + WIDTH data bits, MSB first) from a valid/ready request.
module spi_host_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  busy,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);
  localparam int N  = 8 + WIDTH;
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
  localparam logic [7:0]    DIV_END  = 8'(CLK_DIV - 1);
  localparam logic [7:0]    GAP_END  = 8'(CLK_DIV - 2);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [N-1:0]    sh_q, sh_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic            write_q, write_d;
  logic            cs_n_q, cs_n_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            tick;

  assign tick      = div_q == DIV_END;
  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign rsp_valid = (state_q == DONE) && ena;
  assign rsp_rdata = rdata_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_clk   = sclk_q;
  assign spi_mosi  = mosi_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rdata_d = rdata_q;
    write_d = write_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    if (ena) begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
      case (state_q)
        IDLE: begin
          div_d = 8'd0;
          if (req_valid) begin
            state_d = SETUP;
            sh_d    = {req_write, 7'(req_addr), req_wdata & {WIDTH{req_write}}};
            write_d = req_write;
            cs_n_d  = 1'b0;
            mosi_d  = req_write;
            bit_d   = '0;
          end
        end
        SETUP: begin
          if (tick) begin
            state_d = SHIFT;
            sclk_d  = 1'b1;
          end
        end
        SHIFT: begin
          // Falling edge both samples miso and launches the next mosi bit
          if (tick && sclk_q) begin
            sclk_d = 1'b0;
            sh_d   = {sh_q[N-2:0], spi_miso};
            mosi_d = (bit_q == LAST_BIT) ? 1'b0 : sh_q[N-2];
          end else if (tick) begin
            if (bit_q == LAST_BIT) begin
              state_d = DONE;
              cs_n_d  = 1'b1;
              rdata_d = write_q ? rdata_q : sh_q[WIDTH-1:0];
            end else begin
              sclk_d = 1'b1;
              bit_d  = bit_q + BW'(1);
            end
          end
        end
        DONE: begin
          state_d = GAP;
          div_d   = 8'd0;
        end
        GAP: begin
          // DONE plus GAP keep cs_n high for CLK_DIV cycles before IDLE
          if (div_q == GAP_END) begin
            state_d = IDLE;
            div_d   = 8'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end
endmodule

// File: tb/tb_spi_host_ctrl.sv
// tb_spi_host_ctrl: scoreboard bench with a register-bank slave model (2-cycle miso latency).
module tb_spi_host_ctrl;
  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       ena = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [2:0] req_addr = 3'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       rsp_valid, busy, spi_cs_n, spi_clk, spi_mosi, spi_miso;
  logic [7:0] rsp_rdata;
  logic       r2_valid = 1'b0, r2_ready, r2_rsp, r2_busy, r2_cs, r2_clk, r2_mosi;
  logic [7:0] r2_rdata;

  always #5 clk = ~clk;

  spi_host_ctrl dut (
    .clk(clk), .rstb(rstb), .ena(ena), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_host_ctrl #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rstb(rstb), .ena(ena), .req_valid(r2_valid), .req_ready(r2_ready),
    .req_write(1'b1), .req_addr(3'd1), .req_wdata(8'hFF),
    .rsp_valid(r2_rsp), .rsp_rdata(r2_rdata), .busy(r2_busy),
    .spi_cs_n(r2_cs), .spi_clk(r2_clk), .spi_mosi(r2_mosi), .spi_miso(1'b0)
  );

  // Slave register bank: sees sclk one cycle late, then delays miso two more cycles
  logic [7:0]  s_regs [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00};
  logic [4:0]  s_cnt = 5'd0;
  logic [15:0] s_rx = 16'd0;
  logic [2:0]  s_addr = 3'd0;
  logic [1:0]  s_dly = 2'd0;
  logic        s_bit, s_sclk_p = 1'b0;

  always_comb s_bit = (s_cnt >= 5'd9 && s_cnt <= 5'd16) ? s_regs[s_addr][3'(5'd16 - s_cnt)] : 1'b0;
  assign spi_miso = s_dly[1];

  always @(posedge clk) begin
    s_sclk_p <= spi_clk;
    s_dly    <= {s_dly[0], s_bit};
    if (spi_cs_n) begin
      if (s_cnt == 5'd16 && s_rx[15]) s_regs[s_rx[10:8]] <= s_rx[7:0];
      s_cnt <= 5'd0;
    end else if (spi_clk && !s_sclk_p) begin
      s_rx  <= {s_rx[14:0], spi_mosi};
      s_cnt <= s_cnt + 5'd1;
      if (s_cnt == 5'd7) s_addr <= {s_rx[1:0], spi_mosi};
    end
  end

  typedef struct {
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
    logic [15:0] frame;
    int         low;
  } txn_t;

  txn_t       q[$];
  logic [7:0] mem_m [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00};
  logic [7:0] last_rd = 8'h00;
  logic [15:0] frame = 16'd0;
  int n_cmp = 0, n_err = 0;
  int low_cnt = 0, high_cnt = 0, high_len = 0, rises = 0, rsp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: frame/length checks on cs_n rise, scoreboard pop on rsp_valid
  initial begin
    logic cs_p, sc_p;
    txn_t e;
    cs_p = 1'b1;
    sc_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        cs_p = 1'b1;
        sc_p = 1'b0;
        rises = 0;
        continue;
      end
      if (!spi_cs_n) begin
        if (cs_p) begin
          high_len = high_cnt;
          low_cnt = 0;
          rises = 0;
          frame = 16'd0;
        end
        low_cnt++;
      end else begin
        if (!cs_p) begin
          if (q.size() == 0) chk("orphan_frame", 32'(1), 32'(0));
          else begin
            chk("mosi_frame", 32'(frame), 32'(q[0].frame));
            chk("cs_low_len", 32'(low_cnt), 32'(q[0].low));
            chk("sclk_rises", 32'(rises), 32'(16));
            chk("mosi_after", 32'(spi_mosi), 32'(0));
            chk("rsp_on_rise", 32'(rsp_valid), 32'(1));
          end
          high_cnt = 0;
        end
        high_cnt++;
      end
      if (spi_clk && !sc_p) begin
        frame = {frame[14:0], spi_mosi};
        rises++;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (q.size() == 0) chk("orphan_rsp", 32'(1), 32'(0));
        else begin
          e = q.pop_front();
          if (e.w) begin
            chk("wr_rdata_hold", 32'(rsp_rdata), 32'(last_rd));
            mem_m[e.a] = e.d;
          end else begin
            chk("rd_data", 32'(rsp_rdata), 32'(mem_m[e.a]));
            last_rd = mem_m[e.a];
          end
        end
      end
      cs_p = spi_cs_n;
      sc_p = spi_clk;
    end
  end

  task automatic send(input logic w, input logic [2:0] a, input logic [7:0] d, input int low);
    txn_t e;
    int t = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!(req_ready && ena) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 2000) chk("accept_timeout", 32'(0), 32'(1));
    e.w = w;
    e.a = a;
    e.d = d;
    e.frame = {w, 4'd0, a, w ? d : 8'd0};
    e.low = low;
    q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || !req_ready) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 2000) chk("idle_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    logic f_cs, f_clk, f_mosi;
    int snap, t;
    #23;
    chk("rst_cs_n", 32'(spi_cs_n), 32'(1));
    chk("rst_sclk", 32'(spi_clk), 32'(0));
    chk("rst_mosi", 32'(spi_mosi), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rsp", 32'(rsp_valid), 32'(0));
    chk("rst_rdata", 32'(rsp_rdata), 32'(0));
    rstb = 1'b1;
    @(posedge clk);
    #1;

    snap = rsp_cnt;
    send(1'b1, 3'd2, 8'hA5, 132);
    chk("busy_after_accept", 32'(busy), 32'(1));
    chk("ready_after_accept", 32'(req_ready), 32'(0));
    wait_idle();
    chk("wr_rsp_count", 32'(rsp_cnt - snap), 32'(1));

    send(1'b0, 3'd6, 8'h00, 132);
    wait_idle();

    send(1'b1, 3'd3, 8'h11, 132);
    send(1'b0, 3'd3, 8'h00, 132);
    wait_idle();
    chk("b2b_gap", 32'(high_len), 32'(5));

    send(1'b1, 3'd5, 8'h5A, 152);
    repeat (40) @(posedge clk);
    #1;
    f_cs = spi_cs_n;
    f_clk = spi_clk;
    f_mosi = spi_mosi;
    ena = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("frz_cs_n", 32'(spi_cs_n), 32'(f_cs));
    chk("frz_sclk", 32'(spi_clk), 32'(f_clk));
    chk("frz_mosi", 32'(spi_mosi), 32'(f_mosi));
    ena = 1'b1;
    wait_idle();
    send(1'b0, 3'd5, 8'h00, 132);
    wait_idle();

    snap = rsp_cnt;
    send(1'b1, 3'd4, 8'h77, 132);
    t = 0;
    while (rises < 6 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) chk("bit5_timeout", 32'(0), 32'(1));
    #2;
    rstb = 1'b0;
    #1;
    chk("abort_cs_n", 32'(spi_cs_n), 32'(1));
    chk("abort_sclk", 32'(spi_clk), 32'(0));
    chk("abort_mosi", 32'(spi_mosi), 32'(0));
    chk("abort_ready", 32'(req_ready), 32'(1));
    chk("abort_busy", 32'(busy), 32'(0));
    q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_rsp", 32'(rsp_cnt - snap), 32'(0));
    send(1'b0, 3'd4, 8'h00, 132);
    wait_idle();

    send(1'b1, 3'd7, 8'hC3, 132);
    for (int i = 0; i < 30; i++) begin
      req_valid = ~req_valid;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 3'($urandom_range(0, 7));
      req_wdata = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    wait_idle();
    send(1'b0, 3'd7, 8'h00, 132);
    wait_idle();

    r2_valid = 1'b1;
    @(posedge clk);
    #1;
    r2_valid = 1'b0;
    t = 0;
    while (!r2_cs && t < 500) begin
      t++;
      @(posedge clk);
      #1;
    end
    chk("div2_cs_low", 32'(t), 32'(66));
    chk("div2_rsp", 32'(r2_rsp), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
